// File: rtl/sequenciador_peteleco_if.sv
// Command/status bundle between the move-control FSM and the flick sequencer.
interface sequenciador_peteleco_if;
    logic       iniciar;
    logic [1:0] quantidade;
    logic       posicao;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output iniciar, quantidade,
        input  posicao, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, quantidade,
        output posicao, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/sequenciador_peteleco.sv
// Flick sequencer: runs 0-3 gira/retorno cycles of the servo command and pulses pronto when done.
module sequenciador_peteleco #(
    parameter int unsigned T_GIRA    = 25_000_000,
    parameter int unsigned T_RETORNO = 25_000_000,
    parameter int unsigned W_CONT    = 25
) (
    input  logic                     clock,
    input  logic                     reset,
    sequenciador_peteleco_if.slave   bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        GIRA    = 2'd1,
        RETORNA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [W_CONT-1:0] FIM_GIRA    = W_CONT'(T_GIRA - 1);
    localparam logic [W_CONT-1:0] FIM_RETORNO = W_CONT'(T_RETORNO - 1);

    estado_t           estado;
    logic [W_CONT-1:0] contador;
    logic [1:0]        restantes;
    logic [6:0]        saidas;

    // Output word {posicao, ocupado, pronto, db_estado} for the state being entered.
    function automatic logic [6:0] decodifica(input estado_t e);
        return {e == GIRA, e != OCIOSO, e == FIM, {2'b00, e}};
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            contador  <= '0;
            restantes <= 2'd0;
            saidas    <= 7'd0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        contador <= '0;
                        if (bus.quantidade != 2'd0) begin
                            restantes <= bus.quantidade;
                            estado    <= GIRA;
                            saidas    <= decodifica(GIRA);
                        end else begin
                            estado <= FIM;
                            saidas <= decodifica(FIM);
                        end
                    end
                end
                GIRA: begin
                    if (contador == FIM_GIRA) begin
                        contador <= '0;
                        estado   <= RETORNA;
                        saidas   <= decodifica(RETORNA);
                    end else begin
                        contador <= contador + W_CONT'(1);
                    end
                end
                RETORNA: begin
                    if (contador == FIM_RETORNO) begin
                        contador  <= '0;
                        restantes <= restantes - 2'd1;
                        if (restantes == 2'd1) begin
                            estado <= FIM;
                            saidas <= decodifica(FIM);
                        end else begin
                            estado <= GIRA;
                            saidas <= decodifica(GIRA);
                        end
                    end else begin
                        contador <= contador + W_CONT'(1);
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                    saidas <= decodifica(OCIOSO);
                end
                default: begin
                    estado <= OCIOSO;
                    saidas <= decodifica(OCIOSO);
                end
            endcase
        end
    end

    assign bus.posicao   = saidas[6];
    assign bus.ocupado   = saidas[5];
    assign bus.pronto    = saidas[4];
    assign bus.db_estado = saidas[3:0];

endmodule

// File: tb/tb_sequenciador_peteleco.sv
// Scoreboard bench for the flick sequencer with T_GIRA=4, T_RETORNO=3.
module tb_sequenciador_peteleco;

    localparam int unsigned T_GIRA    = 4;
    localparam int unsigned T_RETORNO = 3;

    // Expected output words {posicao, ocupado, pronto, db_estado}
    localparam logic [6:0] V_OCIOSO  = 7'b000_0000;
    localparam logic [6:0] V_GIRA    = 7'b110_0001;
    localparam logic [6:0] V_RETORNA = 7'b010_0010;
    localparam logic [6:0] V_FIM     = 7'b011_0011;

    logic clock;
    logic reset;
    sequenciador_peteleco_if bus ();

    sequenciador_peteleco #(
        .T_GIRA   (T_GIRA),
        .T_RETORNO(T_RETORNO),
        .W_CONT   (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [6:0] observa();
        return {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected per-cycle words after the start edge for an n-flick command.
    task automatic push_sequencia(input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < int'(T_GIRA); i++)    exp_q.push_back(V_GIRA);
            for (int i = 0; i < int'(T_RETORNO); i++) exp_q.push_back(V_RETORNA);
        end
        exp_q.push_back(V_FIM);
        exp_q.push_back(V_OCIOSO);
    endtask

    // Step one cycle per expected word; iniciar is held for 'hold' edges, optional stray start at 'poke'.
    task automatic drain(input string tag, input int hold, input int poke);
        int c;
        logic [6:0] e;
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            #1;
            c++;
            if (c == hold) bus.iniciar = 1'b0;
            if (poke > 0 && c == poke) begin
                bus.iniciar    = 1'b1;
                bus.quantidade = 2'd3;
            end else if (poke > 0 && c == poke + 1) begin
                bus.iniciar = 1'b0;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, c), observa(), e);
        end
    endtask

    task automatic comando(input logic [1:0] q);
        @(negedge clock);
        bus.iniciar    = 1'b1;
        bus.quantidade = q;
    endtask

    initial begin
        reset          = 1'b0;
        bus.iniciar    = 1'b0;
        bus.quantidade = 2'd0;
        #12;
        check("reset", observa(), V_OCIOSO);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(V_OCIOSO);
        drain("idle", 0, 0);

        comando(2'd1);
        push_sequencia(1);
        drain("um", 1, 0);

        comando(2'd3);
        push_sequencia(3);
        drain("tres", 1, 0);

        comando(2'd0);
        push_sequencia(0);
        drain("zero", 1, 0);

        // Level held across FIM: re-accepted on the first OCIOSO cycle.
        comando(2'd0);
        exp_q.push_back(V_FIM);
        exp_q.push_back(V_OCIOSO);
        exp_q.push_back(V_FIM);
        exp_q.push_back(V_OCIOSO);
        drain("nivel", 3, 0);

        comando(2'd1);
        push_sequencia(1);
        drain("ignora", 1, 2);

        // Reset two cycles into GIRA must clear outputs without a clock edge.
        comando(2'd1);
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("pre_reset", observa(), V_GIRA);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", observa(), V_OCIOSO);
        @(negedge clock);
        reset = 1'b1;
        comando(2'd1);
        push_sequencia(1);
        drain("pos_reset", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
